// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_pkg
// Description : Shared types and default constants for the 1-to-N stream
//               demultiplexer and its output register.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_demux_pkg;

  // Default build parameters for the demux
  localparam int c_NUM_OUTS_DEF = 8;
  localparam int c_DATA_W_DEF   = 8;
  localparam int c_CNT_W_DEF    = 16;

  // Packet-tracking state: no packet open, routing to a locked channel, or
  // swallowing a packet whose select was out of range
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUTE = 2'd1,
    S_DROP  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/stream_demux_1xn_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : stream_out_reg
// Description : One-entry registered stream stage holding valid, last,
//               channel index and payload. Frees and reloads in the same
//               cycle, so a full-rate stream passes with no bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_out_reg #(
  parameter int DATA_W = 8,
  parameter int CH_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic [CH_W-1:0]   i_ch,
  input  logic              i_ready,
  output logic              o_free,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic [CH_W-1:0]   o_ch
);

  // The register contents travel together; ch doubles as the packet lock
  typedef struct packed {
    logic              valid;
    logic              last;
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } oreg_t;

  oreg_t r_reg;

  // Space is available when empty or when the held beat drains this cycle
  assign o_free  = ~r_reg.valid | i_ready;
  assign o_valid = r_reg.valid;
  assign o_data  = r_reg.data;
  assign o_last  = r_reg.last;
  assign o_ch    = r_reg.ch;

  // Load a new beat, otherwise clear valid once the held beat is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg <= '0;
    end else if (i_load) begin
      r_reg <= '{valid: 1'b1, last: i_last, ch: i_ch, data: i_data};
    end else if (r_reg.valid && i_ready) begin
      r_reg.valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_demux_1xn.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_1xn
// Description : Registered 1-to-NUM_OUTS packet demultiplexer with
//               valid/ready backpressure. The channel is sampled on a
//               packet's first beat and held until its last beat; packets
//               with an out-of-range select are swallowed and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_1xn
  import stream_demux_pkg::*;
#(
  parameter int   NUM_OUTS = c_NUM_OUTS_DEF,
  parameter int   DATA_W   = c_DATA_W_DEF,
  parameter int   CNT_W    = c_CNT_W_DEF,
  localparam int  SEL_W    = $clog2(NUM_OUTS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [SEL_W-1:0]    in_sel,
  input  logic                in_last,
  output logic [NUM_OUTS-1:0] out_valid,
  input  logic [NUM_OUTS-1:0] out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  output logic                sel_err,
  output logic [CNT_W-1:0]    drop_cnt
);

  // Ready vector padded to the full select range so indexing by ch is safe
  localparam int               c_PAD_W = 1 << SEL_W;
  localparam logic [SEL_W:0]   c_LIMIT = (SEL_W+1)'(NUM_OUTS);

  state_t             r_state;
  logic               r_sel_err;
  logic [CNT_W-1:0]   r_drop_cnt;

  logic [c_PAD_W-1:0] w_ready_pad;
  logic               w_ready_sel;
  logic               w_free;
  logic               w_reg_valid;
  logic [SEL_W-1:0]   w_ch_q;
  logic [SEL_W-1:0]   w_load_ch;
  logic               w_acc;
  logic               w_sel_ok;
  logic               w_load;

  assign w_ready_pad = c_PAD_W'(out_ready);
  assign w_ready_sel = w_ready_pad[w_ch_q];

  // Inside a dropped packet nothing is stored, so the input never stalls
  assign in_ready = (r_state == S_DROP) | w_free;
  assign w_acc    = in_valid & in_ready;
  assign w_sel_ok = ({1'b0, in_sel} < c_LIMIT);

  // Only the first beat looks at in_sel; later beats reuse the locked channel
  assign w_load_ch = (r_state == S_ROUTE) ? w_ch_q : in_sel;
  assign w_load    = w_acc & ((r_state == S_ROUTE) |
                              ((r_state == S_IDLE) & w_sel_ok));

  stream_out_reg #(
    .DATA_W (DATA_W),
    .CH_W   (SEL_W)
  ) u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_data  (in_data),
    .i_last  (in_last),
    .i_ch    (w_load_ch),
    .i_ready (w_ready_sel),
    .o_free  (w_free),
    .o_valid (w_reg_valid),
    .o_data  (out_data),
    .o_last  (out_last),
    .o_ch    (w_ch_q)
  );

  // Fan the single valid out to the locked channel only
  for (genvar i = 0; i < NUM_OUTS; i++) begin : g_out_valid
    localparam logic [SEL_W-1:0] c_IDX = SEL_W'(i);
    assign out_valid[i] = w_reg_valid & (w_ch_q == c_IDX);
  end

  // Packet tracking FSM with registered error pulse and saturating counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sel_err  <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_sel_err <= 1'b0;
      if (w_acc) begin
        case (r_state)
          S_IDLE: begin
            if (w_sel_ok) begin
              if (!in_last) r_state <= S_ROUTE;
            end else begin
              r_sel_err <= 1'b1;
              if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
              if (!in_last) r_state <= S_DROP;
            end
          end
          S_ROUTE, S_DROP: begin
            if (in_last) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign sel_err  = r_sel_err;
  assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_stream_demux_1xn.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_demux_1xn
// Description : Self-checking bench for stream_demux_1xn. Two instances:
//               A (8 outputs, 8-bit data) and B (6 outputs, 16-bit data,
//               2-bit drop counter). Both see the same stimulus; one is
//               checked at a time against a packet-level scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1xn;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid;
  logic [2:0]  in_sel;
  logic [15:0] in_data;
  logic        in_last;
  logic [7:0]  out_ready;

  logic        a_in_ready;
  logic [7:0]  a_out_valid;
  logic [7:0]  a_out_data;
  logic        a_out_last;
  logic        a_sel_err;
  logic [15:0] a_drop_cnt;

  logic        b_in_ready;
  logic [5:0]  b_out_valid;
  logic [15:0] b_out_data;
  logic        b_out_last;
  logic        b_sel_err;
  logic [1:0]  b_drop_cnt;

  stream_demux_1xn #(.NUM_OUTS(8), .DATA_W(8), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data[7:0]), .in_sel(in_sel), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .sel_err(a_sel_err), .drop_cnt(a_drop_cnt)
  );

  stream_demux_1xn #(.NUM_OUTS(6), .DATA_W(16), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .out_valid(b_out_valid), .out_ready(out_ready[5:0]), .out_data(b_out_data),
    .out_last(b_out_last), .sel_err(b_sel_err), .drop_cnt(b_drop_cnt)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] data;
    logic        last;
    logic        first;
    int          gap;
  } beat_t;

  typedef struct {
    logic [2:0]  ch;
    logic [15:0] data;
    logic        last;
  } exp_t;

  int    n_checks = 0;
  int    n_pass   = 0;

  beat_t stim[$];
  exp_t  expq[$];
  int    pop_k[$];
  int    pop_ch[$];

  bit    use_b;
  bit    rdy_random;
  int    hold_ch;
  int    hold_cycles;
  int    stall_cnt;
  int    sel_err_seen;

  // Packet-level reference state
  int         m_drop;
  bit         m_mid_drop;
  bit         m_exp_sel_err;
  bit         m_cur_drop;
  logic [2:0] m_cur_ch;

  task automatic push_beat(input logic [2:0] sel, input logic [15:0] data,
                           input logic last, input logic first, input int gap);
    beat_t b;
    b.sel = sel; b.data = data; b.last = last; b.first = first; b.gap = gap;
    stim.push_back(b);
  endtask

  task automatic push_random_packet(input int max_gap);
    int          len;
    logic [2:0]  sel;
    len = $urandom_range(1, 4);
    sel = 3'($urandom);
    for (int i = 0; i < len; i++) begin
      push_beat((i == 0) ? sel : 3'($urandom), 16'($urandom), (i == len - 1),
                (i == 0), $urandom_range(0, max_gap));
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_sel = '0; in_data = '0; in_last = 1'b0;
    out_ready = 8'hFF;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stim.delete(); expq.delete();
    m_drop = 0; m_mid_drop = 0; m_exp_sel_err = 0; m_cur_drop = 0; m_cur_ch = '0;
    rdy_random = 0; hold_cycles = 0; hold_ch = 0;
  endtask

  // Drives the queued beats, checks every cycle against the scoreboard
  task automatic run_stream(input string name, input int budget);
    int          k;
    int          gap_left;
    bit          gap_loaded;
    int          n_outs;
    int          cnt_max;
    logic [15:0] dmask;
    logic        o_ir, o_last, o_err, e_ir;
    logic [7:0]  o_valid, e_valid;
    logic [15:0] o_data, o_cnt;
    beat_t       b;
    exp_t        e;
    n_outs  = use_b ? 6 : 8;
    cnt_max = use_b ? 3 : 65535;
    dmask   = use_b ? 16'hFFFF : 16'h00FF;
    k = 0; gap_left = 0; gap_loaded = 0;
    stall_cnt = 0; sel_err_seen = 0;
    pop_k.delete(); pop_ch.delete();
    while ((stim.size() > 0 || expq.size() > 0 || m_exp_sel_err) && k < budget) begin
      @(posedge clk); #1;
      if (stim.size() > 0 && !gap_loaded) begin
        gap_left = stim[0].gap; gap_loaded = 1;
      end
      if (stim.size() > 0 && gap_left == 0) begin
        in_valid = 1'b1; in_sel = stim[0].sel; in_data = stim[0].data; in_last = stim[0].last;
      end else begin
        in_valid = 1'b0; in_sel = 3'($urandom); in_data = 16'($urandom); in_last = 1'($urandom);
        if (gap_left > 0) gap_left--;
      end
      out_ready = rdy_random ? 8'($urandom) : 8'hFF;
      if (k < hold_cycles) out_ready[hold_ch] = 1'b0;

      @(negedge clk);
      o_ir    = use_b ? b_in_ready : a_in_ready;
      o_valid = use_b ? {2'b00, b_out_valid} : a_out_valid;
      o_data  = use_b ? b_out_data : {8'h00, a_out_data};
      o_last  = use_b ? b_out_last : a_out_last;
      o_err   = use_b ? b_sel_err : a_sel_err;
      o_cnt   = use_b ? 16'(b_drop_cnt) : a_drop_cnt;

      e_ir    = m_mid_drop || (expq.size() == 0) || out_ready[expq[0].ch];
      e_valid = (expq.size() > 0) ? (8'd1 << expq[0].ch) : 8'd0;

      n_checks++;
      if (o_ir !== e_ir)
        $display("FAIL %s in_ready k=%0d: got %b want %b", name, k, o_ir, e_ir);
      else n_pass++;

      n_checks++;
      if (o_valid !== e_valid ||
          (expq.size() > 0 && (o_data !== expq[0].data || o_last !== expq[0].last)))
        $display("FAIL %s out k=%0d: got valid=%h data=%h last=%b want valid=%h data=%h last=%b",
                 name, k, o_valid, o_data, o_last, e_valid,
                 (expq.size() > 0) ? expq[0].data : 16'h0,
                 (expq.size() > 0) ? expq[0].last : 1'b0);
      else n_pass++;

      n_checks++;
      if (o_err !== m_exp_sel_err)
        $display("FAIL %s sel_err k=%0d: got %b want %b", name, k, o_err, m_exp_sel_err);
      else n_pass++;

      n_checks++;
      if (o_cnt !== 16'(m_drop))
        $display("FAIL %s drop_cnt k=%0d: got %0d want %0d", name, k, o_cnt, m_drop);
      else n_pass++;

      if (o_err === 1'b1) sel_err_seen++;
      if (in_valid && !o_ir) stall_cnt++;

      if (expq.size() > 0 && out_ready[expq[0].ch]) begin
        pop_k.push_back(k);
        pop_ch.push_back(int'(expq[0].ch));
        e = expq.pop_front();
      end

      m_exp_sel_err = 1'b0;
      if (in_valid && o_ir) begin
        b = stim.pop_front();
        gap_loaded = 0;
        if (b.first) begin
          m_cur_ch   = b.sel;
          m_cur_drop = (int'(b.sel) >= n_outs);
          if (m_cur_drop) begin
            m_exp_sel_err = 1'b1;
            if (m_drop < cnt_max) m_drop++;
          end
        end
        if (!m_cur_drop) begin
          e.ch = m_cur_ch; e.data = b.data & dmask; e.last = b.last;
          expq.push_back(e);
        end
        m_mid_drop = m_cur_drop && !b.last;
      end
      k++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (stim.size() > 0 || expq.size() > 0)
      $display("FAIL %s timeout: %0d beats unsent, %0d beats undelivered, want 0/0",
               name, stim.size(), expq.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (a_out_valid !== 8'h0 || a_out_data !== 8'h0 || a_out_last !== 1'b0 ||
        a_sel_err !== 1'b0 || a_drop_cnt !== 16'h0 || a_in_ready !== 1'b1)
      $display("FAIL reset_a: got valid=%h data=%h last=%b err=%b cnt=%h rdy=%b want 0/0/0/0/0/1",
               a_out_valid, a_out_data, a_out_last, a_sel_err, a_drop_cnt, a_in_ready);
    else n_pass++;
    n_checks++;
    if (b_out_valid !== 6'h0 || b_out_data !== 16'h0 || b_out_last !== 1'b0 ||
        b_sel_err !== 1'b0 || b_drop_cnt !== 2'h0 || b_in_ready !== 1'b1)
      $display("FAIL reset_b: got valid=%h data=%h last=%b err=%b cnt=%h rdy=%b want 0/0/0/0/0/1",
               b_out_valid, b_out_data, b_out_last, b_sel_err, b_drop_cnt, b_in_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    use_b = 0; do_reset();
    push_beat(3'd5, 16'h11, 1'b0, 1'b1, 0);
    push_beat(3'd5, 16'h22, 1'b0, 1'b0, 0);
    push_beat(3'd5, 16'h33, 1'b1, 1'b0, 0);
    run_stream("basic", 50);
    n_checks++;
    if (pop_k.size() != 3 || pop_k[0] != 1 || pop_k[1] != 2 || pop_k[2] != 3 ||
        pop_ch[0] != 5 || pop_ch[2] != 5)
      $display("FAIL basic_timing: got %0d beats, first at cycle %0d, want 3 beats at cycles 1..3 on ch 5",
               pop_k.size(), (pop_k.size() > 0) ? pop_k[0] : -1);
    else n_pass++;
  endtask

  task automatic test_lock();
    bit ok;
    use_b = 0; do_reset();
    push_beat(3'd2, 16'($urandom), 1'b0, 1'b1, 0);
    for (int i = 1; i < 4; i++) push_beat(3'd6, 16'($urandom), (i == 3), 1'b0, 0);
    run_stream("lock", 50);
    ok = (pop_ch.size() == 4);
    foreach (pop_ch[i]) if (pop_ch[i] != 2) ok = 0;
    n_checks++;
    if (!ok) $display("FAIL lock_channel: got %0d beats, want 4 beats all on ch 2", pop_ch.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    use_b = 0; do_reset();
    hold_ch = 3; hold_cycles = 4;
    for (int i = 0; i < 3; i++) push_beat(3'd3, 16'h30 + 16'(i), (i == 2), (i == 0), 0);
    run_stream("backpressure", 50);
    n_checks++;
    if (stall_cnt != 3 || pop_k.size() != 3 || pop_k[0] != 4)
      $display("FAIL backpressure: got stalls=%0d beats=%0d first_drain=%0d want 3/3/4",
               stall_cnt, pop_k.size(), (pop_k.size() > 0) ? pop_k[0] : -1);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    use_b = 1; do_reset();
    push_beat(3'd7, 16'hBEEF, 1'b0, 1'b1, 0);
    push_beat(3'd1, 16'hCAFE, 1'b1, 1'b0, 0);
    run_stream("out_of_range", 50);
    n_checks++;
    if (b_drop_cnt !== 2'd1 || sel_err_seen != 1 || pop_k.size() != 0)
      $display("FAIL out_of_range: got cnt=%0d pulses=%0d delivered=%0d want 1/1/0",
               b_drop_cnt, sel_err_seen, pop_k.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    use_b = 0; do_reset();
    push_beat(3'd0, 16'hA0, 1'b1, 1'b1, 0);
    push_beat(3'd7, 16'hA7, 1'b1, 1'b1, 0);
    run_stream("back_to_back", 50);
    n_checks++;
    if (pop_k.size() != 2 || pop_k[0] != 1 || pop_k[1] != 2 || pop_ch[0] != 0 || pop_ch[1] != 7)
      $display("FAIL back_to_back: got %0d beats (cycles %0d,%0d) want ch0@1 ch7@2",
               pop_k.size(), (pop_k.size() > 0) ? pop_k[0] : -1, (pop_k.size() > 1) ? pop_k[1] : -1);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    use_b = 0; do_reset();
    @(posedge clk); #1;
    in_valid = 1'b1; in_sel = 3'd4; in_data = 16'h41; in_last = 1'b0;
    @(posedge clk); #1;
    in_sel = 3'd4; in_data = 16'h42;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 8'h00;
    #1;
    n_checks++;
    if (a_out_valid !== 8'h10 || a_out_data !== 8'h42)
      $display("FAIL async_pre: got valid=%h data=%h want 10/42", a_out_valid, a_out_data);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (a_out_valid !== 8'h00 || a_out_data !== 8'h00)
      $display("FAIL async_clear: got valid=%h data=%h want 00/00", a_out_valid, a_out_data);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 8'hFF;
    @(posedge clk); #1;
    in_valid = 1'b1; in_sel = 3'd1; in_data = 16'h5A; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (a_out_valid !== 8'h02 || a_out_data !== 8'h5A || a_out_last !== 1'b1)
      $display("FAIL async_after: got valid=%h data=%h last=%b want 02/5a/1",
               a_out_valid, a_out_data, a_out_last);
    else n_pass++;
  endtask

  task automatic test_random(input bit sel_b, input int n_pkts);
    int drops;
    use_b = sel_b; do_reset();
    rdy_random = 1;
    for (int p = 0; p < n_pkts; p++) push_random_packet(2);
    drops = 0;
    foreach (stim[i]) if (stim[i].first && sel_b && stim[i].sel >= 3'd6) drops++;
    run_stream(sel_b ? "random_b" : "random_a", 8000);
    n_checks++;
    if (sel_b ? (b_drop_cnt !== 2'((drops > 3) ? 3 : drops)) : (a_drop_cnt !== 16'h0))
      $display("FAIL random_drop_total: got a=%0d b=%0d for %0d drops", a_drop_cnt, b_drop_cnt, drops);
    else n_pass++;
  endtask

  initial begin
    use_b = 0;
    test_reset();
    test_basic();
    test_lock();
    test_backpressure();
    test_out_of_range();
    test_back_to_back();
    test_async_reset();
    test_random(1'b0, 80);
    test_random(1'b1, 80);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
